writer: RTL and testbench



---
 rtl/writer_pkg.sv | 12 +
 rtl/writer_slot.sv | 28 ++
 rtl/writer.sv | 32 +++
 tb/tb_writer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/writer_pkg.sv
// Shared sizing defaults and slot addressing for the SAR result-assembly register.
package writer_pkg;

    localparam int unsigned NUM_CH_DEF = 8;
    localparam int unsigned WIDTH_DEF  = 10;

    // Base bit position of a channel's slot within the flat result vector.
    function automatic int unsigned slot_base(input int unsigned ch, input int unsigned width);
        return ch * width;
    endfunction

endpackage

// File: rtl/writer_slot.sv
// One channel's result register: each bit loads from d when the channel is selected
// and that SAR step is strobed, otherwise it holds.
module writer_slot
    import writer_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sel,
    input  logic [WIDTH-1:0] bitctrl,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] wr_en;

    assign wr_en = {WIDTH{sel}} & bitctrl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= (q & ~wr_en) | (d & wr_en);
        end
    end

endmodule

// File: rtl/writer.sv
// Result-assembly register for a bank of SAR ADC channels; every selected channel
// captures the currently strobed decision bits of D into its slot of out.
module writer
    import writer_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_CH_DEF,
    parameter int unsigned WIDTH  = WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       ADCctrl,
    input  logic [WIDTH-1:0]        D,
    input  logic [WIDTH-1:0]        bitctrl,
    output logic [NUM_CH*WIDTH-1:0] out
);

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_slot
        localparam int unsigned BASE = slot_base(ch, WIDTH);

        writer_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk     (clk),
            .reset   (reset),
            .sel     (ADCctrl[ch]),
            .bitctrl (bitctrl),
            .d       (D),
            .q       (out[BASE +: WIDTH])
        );
    end

endmodule

// File: tb/tb_writer.sv
// Self-checking bench for writer: directed SAR walks plus randomized writes against a slot-array model.
module tb_writer;

    localparam int unsigned NCH = 8;
    localparam int unsigned W   = 10;
    localparam int unsigned OW  = NCH * W;

    logic           clk;
    logic           reset;
    logic [NCH-1:0] ADCctrl;
    logic [W-1:0]   D;
    logic [W-1:0]   bitctrl;
    logic [OW-1:0]  out;

    logic [W-1:0]   mdl [NCH];
    int             tests;
    int             fails;

    writer #(
        .NUM_CH (NCH),
        .WIDTH  (W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ADCctrl (ADCctrl),
        .D       (D),
        .bitctrl (bitctrl),
        .out     (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [OW-1:0] model_out();
        logic [OW-1:0] r;
        r = '0;
        for (int ch = 0; ch < int'(NCH); ch++) r[ch*W +: W] = mdl[ch];
        return r;
    endfunction

    task automatic model_clear();
        for (int ch = 0; ch < int'(NCH); ch++) mdl[ch] = '0;
    endtask

    task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive inputs, take one rising edge, update the model, and settle 1 time unit past the edge.
    task automatic drive_edge(input logic [NCH-1:0] a, input logic [W-1:0] bc, input logic [W-1:0] d);
        ADCctrl = a;
        bitctrl = bc;
        D       = d;
        @(posedge clk);
        if (!reset) begin
            for (int ch = 0; ch < int'(NCH); ch++)
                for (int b = 0; b < int'(W); b++)
                    if (a[ch] && bc[b]) mdl[ch][b] = d[b];
        end
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        model_clear();
        check("reset_async_clear", out, '0);
        reset = 1'b0;
    endtask

    initial begin
        logic [OW-1:0] snap;
        logic [W-1:0]  bc;
        tests = 0;
        fails = 0;
        model_clear();

        // Reset with arbitrary inputs clears immediately, without a clock edge.
        reset   = 1'b1;
        ADCctrl = '1;
        bitctrl = '1;
        D       = W'($urandom);
        #1;
        check("reset_no_edge", out, '0);
        @(posedge clk);
        #1;
        check("reset_held_edge", out, '0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) drive_edge('0, W'($urandom), W'($urandom));
        check("idle_after_reset", out, '0);

        // Channel 1 conversion, MSB step first.
        for (int i = int'(W) - 1; i >= 0; i--) begin
            drive_edge(8'b0000_0010, W'(1) << i, 10'b1100101011);
            if (i == int'(W) - 1) check("ch1_first_step", out, OW'(10'b1000000000) << 10);
        end
        check("ch1_done", out, OW'(10'h32B) << 10);

        // Channel 4 conversion leaves channel 1 intact.
        for (int i = int'(W) - 1; i >= 0; i--) drive_edge(8'b0001_0000, W'(1) << i, 10'b1100000011);
        check("ch4_done", out, (OW'(10'h303) << 40) | (OW'(10'h32B) << 10));

        // No strobes: nothing changes even though D moves.
        snap = out;
        for (int i = 0; i < 4; i++) begin
            drive_edge(8'b0000_0010, '0, W'($urandom));
            check("idle_strobes", out, snap);
        end

        // Broadcast full word into channels 0 and 7.
        drive_edge(8'b1000_0001, 10'h3FF, 10'h155);
        check("broadcast", out, (OW'(10'h155) << 70) | (OW'(10'h303) << 40) |
                                (OW'(10'h32B) << 10) | OW'(10'h155));

        // Reset mid-conversion discards partial results.
        for (int i = int'(W) - 1; i >= int'(W) - 5; i--) drive_edge(8'b0000_0100, W'(1) << i, W'($urandom));
        check("ch2_partial", out, model_out());
        pulse_reset();
        for (int i = int'(W) - 1; i >= 0; i--) drive_edge(8'b0000_0100, W'(1) << i, 10'h2AA);
        check("ch2_after_reset", out, OW'(10'h2AA) << 20);

        // Randomized traffic: one-hot, multi-hot and empty strobes, occasional resets.
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0:       bc = W'(1) << $urandom_range(0, W - 1);
                1:       bc = '0;
                2:       bc = '1;
                default: bc = W'($urandom);
            endcase
            drive_edge(NCH'($urandom), bc, W'($urandom));
            check("random", out, model_out());
            if ($urandom_range(0, 49) == 0) pulse_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
